matrix_input_assembler: RTL and testbench

- Upstream feeder for the multi-matrix storage block.
- Takes matrix dimensions and then a serial stream of elements from the input front-end (UART/keypad decoder). Assembles them into a row-major, zero-padded 25-element frame.
- Issues a single-cycle write strobe to storage, then reports the storage slot index and overwrite flag it was given.

---
 rtl/matrix_input_assembler.sv | 165 ++++++++++++++++
 tb/tb_matrix_input_assembler.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/matrix_input_assembler.sv
// Collects a rows x cols matrix element by element into a row-major, zero-padded
// MAX_SIZE x MAX_SIZE frame, then issues one write strobe to storage and reports
// the slot index and overwrite flag storage returns.
// Ports: start/dim_row/dim_col/abort control; elem_valid/elem_data/elem_ready element stream;
//        wr_ready/wr_alloc_idx/wr_overwrite/wr_en storage handshake; write_row/write_col/data_flat frame;
//        elem_cnt/busy/done/done_idx/done_ovw/err/err_code status.
module matrix_input_assembler #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_SIZE   = 5,
  parameter int ELEM_MAX   = 9,
  parameter int IDX_W      = 5
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start,
  input  logic [2:0]                               dim_row,
  input  logic [2:0]                               dim_col,
  input  logic                                     abort,
  input  logic                                     elem_valid,
  input  logic [DATA_WIDTH-1:0]                    elem_data,
  output logic                                     elem_ready,
  input  logic                                     wr_ready,
  input  logic [IDX_W-1:0]                         wr_alloc_idx,
  input  logic                                     wr_overwrite,
  output logic                                     wr_en,
  output logic [2:0]                               write_row,
  output logic [2:0]                               write_col,
  output logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0]  data_flat,
  output logic [4:0]                               elem_cnt,
  output logic                                     busy,
  output logic                                     done,
  output logic [IDX_W-1:0]                         done_idx,
  output logic                                     done_ovw,
  output logic                                     err,
  output logic [2:0]                               err_code
);

  localparam logic [2:0]            MAX_DIM  = 3'(MAX_SIZE);
  localparam logic [DATA_WIDTH-1:0] ELEM_LIM = DATA_WIDTH'(ELEM_MAX);

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_COMMIT, S_ISSUE, S_ACK} state_t;

  state_t           state, state_next;
  logic             err_next;
  logic [2:0]       code_next;
  logic             dims_ok, elem_ok, last_elem, accept;
  logic [5:0]       total;
  logic [2:0]       r_pos, c_pos;
  logic [7:0]       slot;
  logic [IDX_W-1:0] done_idx_q;
  logic             done_ovw_q;

  assign dims_ok   = (dim_row != 3'd0) && (dim_row <= MAX_DIM) &&
                     (dim_col != 3'd0) && (dim_col <= MAX_DIM);
  assign elem_ok   = elem_data <= ELEM_LIM;
  assign total     = {3'd0, write_row} * {3'd0, write_col};
  assign last_elem = ({1'b0, elem_cnt} + 6'd1) == total;
  assign accept    = (state == S_COLLECT) && !abort && elem_valid && elem_ok;
  // Row/column position counters avoid a divider for elem_cnt / col and elem_cnt % col.
  assign slot      = {5'd0, r_pos} * 8'(MAX_SIZE) + {5'd0, c_pos};

  assign elem_ready = (state == S_COLLECT);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_ACK);
  // Storage answers during ACK, so the index is passed straight through while done is high
  // and held from the capture register afterwards.
  assign done_idx   = done ? wr_alloc_idx : done_idx_q;
  assign done_ovw   = done ? wr_overwrite : done_ovw_q;

  always_comb begin
    state_next = state;
    err_next   = 1'b0;
    code_next  = err_code;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (dims_ok) begin
            state_next = S_COLLECT;
          end else begin
            err_next  = 1'b1;
            code_next = 3'd1;
          end
        end
      end
      S_COLLECT: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (elem_valid) begin
          if (!elem_ok) begin
            err_next  = 1'b1;
            code_next = 3'd2;
          end else if (last_elem) begin
            state_next = S_COMMIT;
          end
        end
      end
      S_COMMIT: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (wr_ready) begin
          state_next = S_ISSUE;
        end else begin
          err_next   = 1'b1;
          code_next  = 3'd3;
          state_next = S_IDLE;
        end
      end
      S_ISSUE: state_next = S_ACK;
      S_ACK:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wr_en    <= 1'b0;
      err      <= 1'b0;
      err_code <= 3'd0;
    end else begin
      state    <= state_next;
      wr_en    <= (state_next == S_ISSUE);
      err      <= err_next;
      err_code <= code_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_row  <= 3'd1;
      write_col  <= 3'd1;
      data_flat  <= '0;
      elem_cnt   <= 5'd0;
      r_pos      <= 3'd0;
      c_pos      <= 3'd0;
      done_idx_q <= '0;
      done_ovw_q <= 1'b0;
    end else begin
      if (state == S_IDLE && start && dims_ok) begin
        write_row <= dim_row;
        write_col <= dim_col;
        data_flat <= '0;
        elem_cnt  <= 5'd0;
        r_pos     <= 3'd0;
        c_pos     <= 3'd0;
      end else if ((state == S_COLLECT || state == S_COMMIT) && abort) begin
        elem_cnt <= 5'd0;
      end else if (accept) begin
        data_flat[slot*DATA_WIDTH +: DATA_WIDTH] <= elem_data;
        elem_cnt <= elem_cnt + 5'd1;
        if (c_pos == write_col - 3'd1) begin
          c_pos <= 3'd0;
          r_pos <= r_pos + 3'd1;
        end else begin
          c_pos <= c_pos + 3'd1;
        end
      end
      if (state == S_ACK) begin
        done_idx_q <= wr_alloc_idx;
        done_ovw_q <= wr_overwrite;
      end
    end
  end

endmodule

// File: tb/tb_matrix_input_assembler.sv
// Directed-vector bench for matrix_input_assembler.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled there too.
// wr_en strobes are counted on the falling edge.
module tb_matrix_input_assembler;

  localparam int DW = 8;
  localparam int FW = 25 * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort, elem_valid, wr_ready, wr_overwrite;
  logic [2:0]    dim_row, dim_col;
  logic [DW-1:0] elem_data;
  logic [4:0]    wr_alloc_idx;
  logic          elem_ready, wr_en, busy, done, done_ovw, err;
  logic [2:0]    write_row, write_col, err_code;
  logic [FW-1:0] data_flat;
  logic [4:0]    elem_cnt, done_idx;

  int            nvec = 0;
  int            nerr = 0;
  int            wr_cnt = 0;
  logic [FW-1:0] exp_frame;

  matrix_input_assembler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dim_row(dim_row), .dim_col(dim_col),
    .abort(abort), .elem_valid(elem_valid), .elem_data(elem_data), .elem_ready(elem_ready),
    .wr_ready(wr_ready), .wr_alloc_idx(wr_alloc_idx), .wr_overwrite(wr_overwrite),
    .wr_en(wr_en), .write_row(write_row), .write_col(write_col), .data_flat(data_flat),
    .elem_cnt(elem_cnt), .busy(busy), .done(done), .done_idx(done_idx), .done_ovw(done_ovw),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_en === 1'b1) wr_cnt++;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [2:0] r, input logic [2:0] c);
    start = 1'b1; dim_row = r; dim_col = c;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d);
    elem_valid = 1'b1; elem_data = d;
    tick();
    elem_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; elem_valid = 1'b0; elem_data = '0;
    dim_row = 3'd0; dim_col = 3'd0; wr_ready = 1'b1; wr_alloc_idx = 5'd7; wr_overwrite = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("rst_wr_en", wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", elem_ready, 0);
    check("rst_row", write_row, 1);
    check("rst_col", write_col, 1);
    check("rst_frame", data_flat, 0);
    check("rst_err_code", err_code, 0);

    // 2x3 with elements 1..6
    do_start(3'd2, 3'd3);
    check("t1_ready", elem_ready, 1);
    for (int i = 1; i <= 6; i++) send(DW'(i));
    check("t1_commit_wr_en", wr_en, 0);
    check("t1_commit_busy", busy, 1);
    tick();
    check("t1_issue_wr_en", wr_en, 1);
    check("t1_row", write_row, 2);
    check("t1_col", write_col, 3);
    tick();
    check("t1_done", done, 1);
    check("t1_done_idx", done_idx, 7);
    tick();
    check("t1_done_off", done, 0);
    check("t1_idle", busy, 0);
    check("t1_idx_hold", done_idx, 7);
    exp_frame = '0;
    exp_frame[0*DW +: DW] = 8'd1; exp_frame[1*DW +: DW] = 8'd2; exp_frame[2*DW +: DW] = 8'd3;
    exp_frame[5*DW +: DW] = 8'd4; exp_frame[6*DW +: DW] = 8'd5; exp_frame[7*DW +: DW] = 8'd6;
    check("t1_frame", data_flat, exp_frame);
    check("t1_wr_cnt", wr_cnt, 1);

    // bad dimensions
    do_start(3'd0, 3'd3);
    check("t2a_err", err, 1);
    check("t2a_code", err_code, 1);
    check("t2a_busy", busy, 0);
    tick();
    check("t2a_err_pulse", err, 0);
    check("t2a_code_hold", err_code, 1);
    do_start(3'd6, 3'd2);
    check("t2b_err", err, 1);
    check("t2b_code", err_code, 1);
    check("t2b_busy", busy, 0);
    check("t2b_row_kept", write_row, 2);
    check("t2_wr_cnt", wr_cnt, 1);

    // 1x1 with a rejected element first
    do_start(3'd1, 3'd1);
    send(8'd12);
    check("t3_err", err, 1);
    check("t3_code", err_code, 2);
    check("t3_cnt0", elem_cnt, 0);
    check("t3_busy", busy, 1);
    send(8'd4);
    check("t3_cnt1", elem_cnt, 1);
    tick();
    check("t3_wr_en", wr_en, 1);
    tick();
    check("t3_done", done, 1);
    tick();
    check("t3_frame", data_flat, 4);
    check("t3_wr_cnt", wr_cnt, 2);

    // 5x5 gapped stream
    do_start(3'd5, 3'd5);
    exp_frame = '0;
    for (int k = 0; k < 25; k++) begin
      exp_frame[k*DW +: DW] = DW'((k % 9) + 1);
      send(DW'((k % 9) + 1));
      if (k < 24) tick();
    end
    check("t4_cnt", elem_cnt, 25);
    check("t4_wr_en_n1", wr_en, 0);
    tick();
    check("t4_wr_en_n2", wr_en, 1);
    tick();
    check("t4_done", done, 1);
    tick();
    check("t4_frame", data_flat, exp_frame);
    check("t4_wr_cnt", wr_cnt, 3);

    // storage not ready, then a retry with overwrite
    wr_ready = 1'b0;
    do_start(3'd1, 3'd1);
    send(8'd3);
    tick();
    check("t5_err", err, 1);
    check("t5_code", err_code, 3);
    check("t5_busy", busy, 0);
    check("t5_wr_cnt", wr_cnt, 3);
    wr_ready = 1'b1; wr_overwrite = 1'b1; wr_alloc_idx = 5'd9;
    do_start(3'd1, 3'd1);
    send(8'd5);
    tick();
    tick();
    check("t5_done", done, 1);
    check("t5_done_ovw", done_ovw, 1);
    check("t5_done_idx", done_idx, 9);
    tick();
    check("t5_ovw_hold", done_ovw, 1);
    wr_overwrite = 1'b0;

    // abort after 3 of 4, then a clean 2x2
    do_start(3'd2, 3'd2);
    check("t6_cleared", data_flat, 0);
    send(8'd7); send(8'd8); send(8'd9);
    abort = 1'b1; elem_valid = 1'b1; elem_data = 8'd1;
    tick();
    abort = 1'b0; elem_valid = 1'b0;
    check("t6_abort_busy", busy, 0);
    check("t6_abort_cnt", elem_cnt, 0);
    check("t6_abort_err", err, 0);
    tick();
    check("t6_abort_wr_cnt", wr_cnt, 4);
    do_start(3'd2, 3'd2);
    check("t6_no_stale", data_flat, 0);
    send(8'd1); send(8'd2); send(8'd3); send(8'd4);
    tick();
    tick();
    check("t6_done", done, 1);
    tick();
    exp_frame = '0;
    exp_frame[0*DW +: DW] = 8'd1; exp_frame[1*DW +: DW] = 8'd2;
    exp_frame[5*DW +: DW] = 8'd3; exp_frame[6*DW +: DW] = 8'd4;
    check("t6_frame", data_flat, exp_frame);
    check("t6_wr_cnt", wr_cnt, 5);

    // asynchronous reset while wr_en is high
    do_start(3'd1, 3'd1);
    send(8'd2);
    tick();
    check("t7_issue", wr_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_wr_en_drop", wr_en, 0);
    check("t7_busy", busy, 0);
    check("t7_row", write_row, 1);
    check("t7_frame", data_flat, 0);
    check("t7_cnt", elem_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t7_wr_cnt", wr_cnt, 5);
    check("t7_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
